// File: rtl/pipeline_fwd_pkg.sv
// Shared definitions for the 3-stage forwarding ALU pipeline: opcodes,
// instruction field positions and the decoded-instruction record.
package pipeline_fwd_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 29;
  localparam int ISEL_B  = 28;
  localparam int WE_B    = 27;
  localparam int RD_HI   = 26;
  localparam int RD_LO   = 22;
  localparam int RS1_HI  = 21;
  localparam int RS1_LO  = 17;
  localparam int RS2_HI  = 16;
  localparam int RS2_LO  = 12;
  localparam int IMM_HI  = 11;
  localparam int IMM_LO  = 0;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        imm_sel;
    logic        we;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d.alu_op  = w[OP_HI:OP_LO];
    d.imm_sel = w[ISEL_B];
    d.we      = w[WE_B];
    d.rd      = w[RD_HI:RD_LO];
    d.rs1     = w[RS1_HI:RS1_LO];
    d.rs2     = w[RS2_HI:RS2_LO];
    d.imm     = w[IMM_HI:IMM_LO];
    return d;
  endfunction

endpackage

// File: rtl/alu_param.sv
// Combinational DW-bit ALU; shifts use only the low log2(DW) bits of b.
module alu_param
  import pipeline_fwd_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  localparam int SW = $clog2(DW);

  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: y = a << sh;
      ALU_SRL: y = a >> sh;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_fwd.sv
// 3-stage in-order ALU pipeline (S1 decode/read, S2 execute, S3 writeback)
// resolving RAW hazards by forwarding (FWD_EN=1) or by an S1 interlock.
module pipeline_fwd
  import pipeline_fwd_pkg::*;
#(
  parameter int DW     = 32,
  parameter int FWD_EN = 1,
  parameter int NREGS  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr_in,
  output logic          out_valid,
  output logic          out_we,
  output logic [4:0]    out_rd,
  output logic [DW-1:0] out_data
);
  localparam bit FWD = (FWD_EN != 0);

  logic [NREGS-1:0][DW-1:0] rf_q, rf_d;
  logic [3:1]               vld_pipe_q, vld_pipe_d;
  dec_t                     s1_q, s1_d;
  logic [2:0]               s2_op_q, s2_op_d;
  logic                     s2_imm_sel_q, s2_imm_sel_d, s2_we_q, s2_we_d;
  logic [4:0]               s2_rd_q, s2_rd_d, s2_rs1_q, s2_rs1_d, s2_rs2_q, s2_rs2_d;
  logic [DW-1:0]            s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic                     s3_we_q, s3_we_d;
  logic [4:0]               s3_rd_q, s3_rd_d;
  logic [DW-1:0]            s3_data_q, s3_data_d;

  logic          s2_wr, s3_wr, hz1, hz2, stall, fwd_a, fwd_b;
  logic [DW-1:0] rs1_val, rs2_val, imm_ext, alu_a, alu_b, alu_y;

  assign s2_wr   = vld_pipe_q[2] && s2_we_q;
  assign s3_wr   = vld_pipe_q[3] && s3_we_q;
  assign imm_ext = DW'($signed(s1_q.imm));

  // Register read with write-through from the instruction retiring this cycle.
  always_comb begin
    rs1_val = rf_q[s1_q.rs1];
    if (s3_wr && s3_rd_q == s1_q.rs1) rs1_val = s3_data_q;
    if (s1_q.rs1 == '0) rs1_val = '0;
    rs2_val = rf_q[s1_q.rs2];
    if (s3_wr && s3_rd_q == s1_q.rs2) rs2_val = s3_data_q;
    if (s1_q.rs2 == '0) rs2_val = '0;
  end

  assign hz1 = (s1_q.rs1 != '0) &&
               ((s2_wr && s2_rd_q == s1_q.rs1) || (s3_wr && s3_rd_q == s1_q.rs1));
  assign hz2 = !s1_q.imm_sel && (s1_q.rs2 != '0) &&
               ((s2_wr && s2_rd_q == s1_q.rs2) || (s3_wr && s3_rd_q == s1_q.rs2));
  assign stall    = !FWD && vld_pipe_q[1] && (hz1 || hz2);
  assign in_ready = !stall;

  assign fwd_a = FWD && s3_wr && (s3_rd_q != '0) && (s3_rd_q == s2_rs1_q);
  assign fwd_b = FWD && s3_wr && !s2_imm_sel_q && (s3_rd_q != '0) && (s3_rd_q == s2_rs2_q);
  assign alu_a = fwd_a ? s3_data_q : s2_a_q;
  assign alu_b = fwd_b ? s3_data_q : s2_b_q;

  alu_param #(.DW(DW)) u_alu (
    .op (s2_op_q),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    if (!stall) begin
      vld_pipe_d[1] = in_valid;
      s1_d          = decode(instr_in);
    end
    // A held S1 instruction leaves a bubble behind it in S2.
    vld_pipe_d[2] = vld_pipe_q[1] && !stall;
    s2_op_d       = s1_q.alu_op;
    s2_imm_sel_d  = s1_q.imm_sel;
    s2_we_d       = s1_q.we;
    s2_rd_d       = s1_q.rd;
    s2_rs1_d      = s1_q.rs1;
    s2_rs2_d      = s1_q.rs2;
    s2_a_d        = rs1_val;
    s2_b_d        = s1_q.imm_sel ? imm_ext : rs2_val;
    vld_pipe_d[3] = vld_pipe_q[2];
    s3_we_d       = vld_pipe_q[2] && s2_we_q;
    s3_rd_d       = vld_pipe_q[2] ? s2_rd_q : '0;
    s3_data_d     = vld_pipe_q[2] ? alu_y : '0;
    rf_d          = rf_q;
    if (s3_wr && s3_rd_q != '0) rf_d[s3_rd_q] = s3_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q         <= '0;
      vld_pipe_q   <= '0;
      s1_q         <= '0;
      s2_op_q      <= '0;
      s2_imm_sel_q <= 1'b0;
      s2_we_q      <= 1'b0;
      s2_rd_q      <= '0;
      s2_rs1_q     <= '0;
      s2_rs2_q     <= '0;
      s2_a_q       <= '0;
      s2_b_q       <= '0;
      s3_we_q      <= 1'b0;
      s3_rd_q      <= '0;
      s3_data_q    <= '0;
    end else begin
      rf_q         <= rf_d;
      vld_pipe_q   <= vld_pipe_d;
      s1_q         <= s1_d;
      s2_op_q      <= s2_op_d;
      s2_imm_sel_q <= s2_imm_sel_d;
      s2_we_q      <= s2_we_d;
      s2_rd_q      <= s2_rd_d;
      s2_rs1_q     <= s2_rs1_d;
      s2_rs2_q     <= s2_rs2_d;
      s2_a_q       <= s2_a_d;
      s2_b_q       <= s2_b_d;
      s3_we_q      <= s3_we_d;
      s3_rd_q      <= s3_rd_d;
      s3_data_q    <= s3_data_d;
    end
  end

  assign out_valid = vld_pipe_q[3];
  assign out_we    = s3_we_q;
  assign out_rd    = s3_rd_q;
  assign out_data  = s3_data_q;

endmodule

// File: doc/pipeline_fwd.md
Name: pipeline_fwd

Overview:
Parametrised 3-stage in-order ALU pipeline: S1 decode/register read, S2 execute, S3 writeback.
- Successor to the fixed 32-bit three-register pipeline.
- Adds a data-width parameter, a valid/ready instruction handshake, and a valid-tagged result port.
- Adds RAW hazard resolution, either by full forwarding or by a stall interlock, selected by parameter.
- Sits between the instruction source (bench or fetch) and any result consumer.

Parameters:
DW, 32, datapath and register width (8..64); immediates sign-extend to DW.
FWD_EN, 1, 1 = full forwarding with no stalls; 0 = interlock with bubble insertion.
NREGS, 32, register count; fixed by the 5-bit register fields; r0 reads as zero and ignores writes.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  instr_in carries an instruction this cycle.
in_ready  out  1  S1 accepts an instruction this cycle.
instr_in  in  32  instruction word.
out_valid  out  1  S3 holds a retired instruction.
out_we  out  1  retired instruction wrote the register file.
out_rd  out  5  destination register of the retired instruction.
out_data  out  DW  ALU result of the retired instruction.

Behaviour:
- Instruction format:
  - [31:29] alu_op; [28] imm_sel (1: B = imm); [27] we.
  - [26:22] rd; [21:17] rs1; [16:12] rs2.
  - [11:0] imm12, sign-extended to DW.
- alu_op encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLT: signed, result 1 or 0.
  - 110 SLL and 111 SRL: shift amount is B[$clog2(DW)-1:0].
  - All results are mod 2^DW.
- Reset (async): all stage valids, out_* and every register-file entry go to 0 immediately. in_ready is 1 in the first cycle after reset deassertion.
- Transfer into S1 occurs when in_valid && in_ready. With no transfer, S1 loads a bubble (valid = 0).
- Stages advance every cycle; there is no output back-pressure.
- Latency with no stall: an instruction accepted at edge N appears on out_* after edge N+2, so it is valid during cycle N+2..N+3.
- Register-file write: at the clock edge when S3 is valid, we = 1 and rd != 0. A write to r0 is dropped, and out_we still reports the instruction's we bit.
- Source usage: rs1 is always used. rs2 is used only when imm_sel = 0.
- FWD_EN = 1 (forwarding paths):
  - Write-through: an S1 read of register x while S3 writes x returns S3 data.
  - S3 to S2 forwarding: S2 operand x is taken from the S3 result when S3 is valid, we = 1, and rd == x != 0.
  - No stalls; in_ready is tied to 1.
- FWD_EN = 0 (interlock):
  - in_ready = 0 and S1 holds while S1 is valid and a used source x != 0 matches the rd of a valid, we = 1 instruction in S2 or S3.
  - A bubble is inserted into S2 each stall cycle.
  - Register-file reads are still write-through, so the dependency clears once the producer leaves S3. Back-to-back dependents therefore cost 2 bubbles.
- Simultaneous events:
  - A forward from S3 takes priority over a stale register-file value.
  - rs1 == rs2 forwards both operands.
  - An instruction with we = 0 never forwards or stalls anything.
- Reset mid-operation: all in-flight instructions are discarded and none retire.
- Assertion: out_valid never rises without a prior accepted instruction.

Decomposition:
- Package pipeline_fwd_pkg holds:
  - alu_op localparams (ALU_ADD..ALU_SRL).
  - Instruction field bit positions.
  - A struct typedef for the decoded S1 fields: alu_op, imm_sel, we, rd, rs1, rs2, imm.
- Sub-module alu_param (parameter DW): purely combinational; inputs op, a, b; output y.
- The register file, forwarding muxes and interlock stay in the top level.

Test Plan:
1. Reset, then ADD-imm r1 = r0 + 5, then ADD-imm r2 = r0 + (-3). Expect out_data 5 then 0xFFFFFFFD, on consecutive cycles, 2 cycles after each accept.
2. FWD_EN = 1, back-to-back: r1 = r0 + 7; r2 = r1 + r1; r3 = r2 - r1. Expect 7, 14, 7 on 3 consecutive cycles, with in_ready constantly 1.
3. FWD_EN = 0, same sequence. Expect the same values, with in_ready low for 2 cycles before each dependent and out_valid gaps of 2 cycles.
4. DW = 8: r1 = r0 + 0x7F, then r2 = r1 + 1, then SLT r3 = r2 < r1. Expect 0x80, then 1 (signed).
5. Write to r0 (r0 = r0 + 9), then r1 = r0 + 0. Expect out_data 9 with out_rd 0, then r1 result 0; there is no forward from r0.
6. Assert rst for 1 cycle while 3 instructions are in flight. Expect out_valid = 0 immediately, nothing retires afterward, and a read of r1 returns 0.
